uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART transmitter among NUM_REQ byte producers.
- Arbitrates between requesters, loads the winner's byte and parity configuration onto the transmitter inputs, and pulses the transmitter's data-valid input.
- Tracks the transmitter's Busy flag to completion, then acknowledges the requester. Sits directly in front of the UART TX block in the system top.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- Width, 8, data word width, matching the UART TX Width.
- BUSY_TIMEOUT, 4, cycles allowed after the data-valid pulse for Busy to rise before the frame is declared lost.

Ports:
- CLK  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- req  input  NUM_REQ  per-requester transmit request, level; held until ack.
- req_data  input  NUM_REQ*Width  packed bytes; requester i occupies [i*Width +: Width]; stable while req[i] is high.
- req_par_en  input  NUM_REQ  per-requester parity enable.
- req_par_typ  input  NUM_REQ  per-requester parity type.
- ack  output  NUM_REQ  one-cycle pulse: requester's frame fully transmitted.
- grant  output  NUM_REQ  one-hot owner of the transmitter; 0 when idle.
- P_data  output  Width  byte to the transmitter.
- Data_valid  output  1  one-cycle load strobe to the transmitter.
- PAR_EN  output  1  parity enable to the transmitter.
- PAR_TYP  output  1  parity type to the transmitter.
- Busy  input  1  transmitter busy flag.
- err  output  1  one-cycle pulse on Busy timeout.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, grant=0, ack=0, P_data=0, Data_valid=0, PAR_EN=0, PAR_TYP=0, err=0, rr_ptr=0, timeout counter=0.
- Reset asserted mid-frame aborts immediately to these values. No ack is issued for the aborted frame.

State machine IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> IDLE:
- IDLE:
  - Proceeds only when any eligible req is high and Busy=0. If Busy=1 while in IDLE, the arbiter waits and issues nothing.
  - Winner = first set eligible req searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - On the transition edge it registers: grant=onehot(winner), P_data=winner's byte, PAR_EN/PAR_TYP=winner's config, Data_valid=1.
  - Latency: req high in cycle N -> Data_valid visible in cycle N+1.
- ISSUE: lasts exactly one cycle with Data_valid=1. Next edge: Data_valid=0, counter=0, state=WAIT_BUSY.
- WAIT_BUSY:
  - Busy=1 -> WAIT_DONE.
  - Otherwise the counter increments. When the counter reaches BUSY_TIMEOUT-1 without Busy: err=1 for one cycle, grant=0, rr_ptr=winner+1 (mod NUM_REQ), state=IDLE.
  - No ack on timeout; the requester keeps req high and is retried in round-robin order.
- WAIT_DONE: waits for Busy=0. Then ack[winner]=1 for one cycle, grant=0, rr_ptr=winner+1 (mod NUM_REQ), state=IDLE.

Holding and fairness rules:
- P_data, PAR_EN and PAR_TYP hold their values from ISSUE through WAIT_DONE. Requester input changes during a frame have no effect.
- In the cycle ack[i] is high, req[i] is masked from arbitration, so the requester has one cycle to drop req or present new data.
- A requester that keeps req high after that cycle is treated as a new request.
- At most one ack bit and one grant bit are ever high. ack and err are never high together.
- Requests arriving or dropping mid-frame do not affect the current frame.
- A req dropped before its grant is simply not served.
- Fairness: with all requests held high, grants rotate 0,1,...,NUM_REQ-1,0, and so on.

Test Plan:
- Single request: req=4'b0010, req_data[15:8]=8'hA5, par_en=1, typ=0; Busy model rises 1 cycle after Data_valid and lasts 11 cycles -> Data_valid is one pulse the cycle after req, with P_data=8'hA5 and grant=4'b0010; PAR_EN=1 and PAR_TYP=0 stable through the frame; ack=4'b0010 for one cycle after Busy falls; no err.
- Round-robin: req=4'b1111 held, all bytes distinct -> grant order 0,1,2,3,0; each ack matches the preceding grant; no requester is served twice in a row.
- Ack masking: req=4'b0001 held continuously -> back-to-back frames from requester 0 with at least one idle cycle (the ack cycle) between the end of Busy and the next Data_valid.
- Busy timeout: Busy tied 0, req=4'b0100 -> err pulses exactly BUSY_TIMEOUT cycles after the Data_valid pulse; no ack; grant=0; requester 2 retried on the next arbitration.
- Busy stuck high while idle: Busy=1, req=4'b0001 -> no Data_valid until Busy=0; issue happens the cycle after Busy falls.
- Reset mid-frame: assert rst during WAIT_DONE -> next cycle all outputs are 0, state is IDLE, no ack; arbitration restarts from requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler that shares one UART transmitter among NUM_REQ byte producers.
// It issues the winner's byte with a one-cycle Data_valid, follows Busy to completion, then acks.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int Width        = 8,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*Width-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_par_en,
    input  logic [NUM_REQ-1:0]       req_par_typ,
    output logic [NUM_REQ-1:0]       ack,
    output logic [NUM_REQ-1:0]       grant,
    output logic [Width-1:0]         P_data,
    output logic                     Data_valid,
    output logic                     PAR_EN,
    output logic                     PAR_TYP,
    input  logic                     Busy,
    output logic                     err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic [NUM_REQ-1:0] ack_reg, ack_next;
    logic [Width-1:0]   p_data_reg, p_data_next;
    logic               dv_reg, dv_next;
    logic               par_en_reg, par_en_next;
    logic               par_typ_reg, par_typ_next;
    logic               err_reg, err_next;
    logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [PTR_W-1:0]   owner_reg, owner_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [CNT_W-1:0]   cnt_inc;

    logic [NUM_REQ-1:0] eligible;
    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   cand;
    logic [Width-1:0]   req_byte [NUM_REQ];

    // Index arithmetic modulo NUM_REQ, valid for any NUM_REQ (not only powers of two).
    function automatic logic [PTR_W-1:0] ptr_wrap(input int v);
        int w;
        w = v;
        if (w >= NUM_REQ) begin
            w = w - NUM_REQ;
        end
        return PTR_W'(w);
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_byte[gi] = req_data[gi*Width +: Width];
        end
    endgenerate

    // The requester being acked this cycle sits out one arbitration round.
    assign eligible = req & ~ack_reg;

    // Descending scan so the smallest offset from rr_ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr_wrap(int'(rr_ptr_reg) + k);
            if (eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        grant_next   = grant_reg;
        ack_next     = '0;
        p_data_next  = p_data_reg;
        dv_next      = 1'b0;
        par_en_next  = par_en_reg;
        par_typ_next = par_typ_reg;
        err_next     = 1'b0;
        rr_ptr_next  = rr_ptr_reg;
        owner_next   = owner_reg;
        cnt_next     = cnt_reg;
        cnt_inc      = cnt_reg + CNT_W'(1);

        case (state_reg)
            IDLE: begin
                if (win_found && !Busy) begin
                    state_next   = ISSUE;
                    owner_next   = win_idx;
                    grant_next   = onehot(win_idx);
                    p_data_next  = req_byte[win_idx];
                    par_en_next  = req_par_en[win_idx];
                    par_typ_next = req_par_typ[win_idx];
                    dv_next      = 1'b1;
                end
            end
            ISSUE: begin
                state_next = WAIT_BUSY;
                cnt_next   = '0;
            end
            WAIT_BUSY: begin
                if (Busy) begin
                    state_next = WAIT_DONE;
                end else if (cnt_inc == CNT_LAST) begin
                    // Frame lost: release without ack, the requester is retried later.
                    state_next  = IDLE;
                    err_next    = 1'b1;
                    grant_next  = '0;
                    rr_ptr_next = ptr_wrap(int'(owner_reg) + 1);
                    cnt_next    = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            WAIT_DONE: begin
                if (!Busy) begin
                    state_next  = IDLE;
                    ack_next    = onehot(owner_reg);
                    grant_next  = '0;
                    rr_ptr_next = ptr_wrap(int'(owner_reg) + 1);
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_reg   <= IDLE;
            grant_reg   <= '0;
            ack_reg     <= '0;
            p_data_reg  <= '0;
            dv_reg      <= 1'b0;
            par_en_reg  <= 1'b0;
            par_typ_reg <= 1'b0;
            err_reg     <= 1'b0;
            rr_ptr_reg  <= '0;
            owner_reg   <= '0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            ack_reg     <= ack_next;
            p_data_reg  <= p_data_next;
            dv_reg      <= dv_next;
            par_en_reg  <= par_en_next;
            par_typ_reg <= par_typ_next;
            err_reg     <= err_next;
            rr_ptr_reg  <= rr_ptr_next;
            owner_reg   <= owner_next;
            cnt_reg     <= cnt_next;
        end
    end

    assign ack        = ack_reg;
    assign grant      = grant_reg;
    assign P_data     = p_data_reg;
    assign Data_valid = dv_reg;
    assign PAR_EN     = par_en_reg;
    assign PAR_TYP    = par_typ_reg;
    assign err        = err_reg;

endmodule
